// File: rtl/psum_accum.sv
// Pops OFIFO psum rows, accumulates them per column over several passes, then
// drains the finished rows on a valid/ready port. Optional ReLU on drain: PSUM_ACCUM_RELU_EN.

module psum_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic [W:0] full;

    assign full = {a[W-1], a} + {b[W-1], b};

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    always_comb begin
        sum = full[W-1:0];
        if (full[W] != full[W-1])
            sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
endmodule

module psum_accum #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 16,
    parameter int AW      = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [AW-1:0]          num_pix_m1,
    input  logic [7:0]             num_pass_m1,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);
    localparam int RW = col * psum_bw;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t                  state;
    logic [AW-1:0]           pix, pix_last, pix_nxt;
    logic [7:0]              pass, pass_last;
    logic [depth-1:0][RW-1:0] row_mem;
    logic [RW-1:0]           rd_row, acc_row;
    logic                    pop;

    assign pop      = (state == ACC) && ofifo_valid;
    assign ofifo_rd = pop && reset;
    assign busy     = (state != IDLE);
    assign pix_nxt  = pix + 1'b1;
    assign rd_row   = row_mem[pix];

    for (genvar c = 0; c < col; c++) begin : g_col
        psum_sat_add #(.W(psum_bw)) u_add (
            .a   (rd_row[c*psum_bw +: psum_bw]),
            .b   (ofifo_out[c*psum_bw +: psum_bw]),
            .sum (acc_row[c*psum_bw +: psum_bw])
        );
    end

    function automatic logic [RW-1:0] post(input logic [RW-1:0] r);
        logic [RW-1:0] o;
        o = r;
`ifdef PSUM_ACCUM_RELU_EN
        for (int c = 0; c < col; c++)
            if (r[c*psum_bw + psum_bw - 1])
                o[c*psum_bw +: psum_bw] = '0;
`endif
        return o;
    endfunction

    // Buffer is not reset; pass 0 always overwrites before any read.
    always_ff @(posedge clk) begin
        if (reset && pop)
            row_mem[pix] <= (pass == 8'd0) ? ofifo_out : acc_row;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pix       <= '0;
            pix_last  <= '0;
            pass      <= '0;
            pass_last <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pix_last  <= num_pix_m1;
                    pass_last <= num_pass_m1;
                    pix       <= '0;
                    pass      <= '0;
                    state     <= ACC;
                end
                ACC: if (ofifo_valid) begin
                    if (pix == pix_last) begin
                        pix  <= '0;
                        pass <= pass + 8'd1;
                        if (pass == pass_last)
                            state <= DRAIN;
                    end else begin
                        pix <= pix_nxt;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle only loads the output register.
                    if (!out_valid) begin
                        out_data  <= post(rd_row);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (pix == pix_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            pix      <= pix_nxt;
                            out_data <= post(row_mem[pix_nxt]);
                        end
                    end
                end
                DONE: begin
                    pix   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: OFIFO queue model, output collector, per-scenario tasks.

module tb_psum_accum;
    logic         clk = 1'b0;
    logic         reset, start, ofifo_valid, ofifo_rd, out_valid, out_ready, busy, done;
    logic [3:0]   num_pix_m1;
    logic [7:0]   num_pass_m1;
    logic [127:0] ofifo_out, out_data;

    int compares = 0;
    int fails = 0;

    psum_accum dut (
        .clk(clk), .reset(reset), .start(start), .num_pix_m1(num_pix_m1),
        .num_pass_m1(num_pass_m1), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
        .ofifo_rd(ofifo_rd), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [127:0] q[$];
    logic [127:0] outq[$];
    logic tog = 1'b0, gate = 1'b1, ov_d = 1'b0;
    int cyc = 0, rd_bad = 0, pop_cyc = 0, xfer_cyc = 0, ov_rise_cyc = 0, done_cnt = 0, done_cyc = 0;

    // OFIFO head presented at negedge; pops and output transfers collected at posedge.
    always @(negedge clk) begin
        gate = tog ? ~gate : 1'b1;
        ofifo_valid = gate && (q.size() > 0);
        ofifo_out = (q.size() > 0) ? q[0] : '0;
    end

    always @(posedge clk) begin
        cyc++;
        if (ofifo_rd) begin
            if (!ofifo_valid || q.size() == 0) rd_bad++;
            else void'(q.pop_front());
            pop_cyc = cyc;
        end
        if (out_valid && !ov_d) ov_rise_cyc = cyc;
        ov_d = out_valid;
        if (out_valid && out_ready) begin
            outq.push_back(out_data);
            xfer_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [127:0] row_all(input logic [15:0] v);
        logic [127:0] r;
        for (int c = 0; c < 8; c++) r[c*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [127:0] rl(input logic [127:0] r);
        logic [127:0] o;
        o = r;
`ifdef PSUM_ACCUM_RELU_EN
        for (int c = 0; c < 8; c++) if (r[c*16 + 15]) o[c*16 +: 16] = '0;
`endif
        return o;
    endfunction

    task automatic start_tile(input logic [3:0] p, input logic [7:0] n);
        @(negedge clk);
        num_pix_m1 = p;
        num_pass_m1 = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int k = 0;
        while (done_cnt == d0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset;
        #1;
        compares += 5;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b need 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b need 0", done); end
        if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h need 0", out_data); end
        if (ofifo_rd !== 1'b0) begin fails++; $display("FAIL reset_ofifo_rd got %b need 0", ofifo_rd); end
        reset = 1'b1;
    endtask

    task automatic test_single_pass;
        logic [127:0] exp[4];
        bit ok;
        int d0;
        exp[0] = rl(row_all(16'd5));
        exp[1] = rl(row_all(-16'sd2));
        exp[2] = rl(row_all(16'd7));
        exp[3] = rl(row_all(16'd0));
        @(negedge clk); #1;
        outq.delete();
        q.push_back(row_all(16'd5));
        q.push_back(row_all(-16'sd2));
        q.push_back(row_all(16'd7));
        q.push_back(row_all(16'd0));
        d0 = done_cnt;
        start_tile(4'd3, 8'd0);
        wait_done(d0, ok);
        compares++;
        if (!ok) begin fails++; $display("FAIL single_timeout got no done need done"); end
        repeat (3) @(negedge clk);
        compares++;
        if (outq.size() != 4) begin fails++; $display("FAIL single_count got %0d need 4", outq.size()); end
        for (int i = 0; i < 4; i++) begin
            compares++;
            if (i >= outq.size() || outq[i] !== exp[i]) begin
                fails++;
                $display("FAIL single_row%0d got %h need %h", i, (i < outq.size()) ? outq[i] : '0, exp[i]);
            end
        end
        compares += 4;
        if (ov_rise_cyc != pop_cyc + 2) begin fails++; $display("FAIL pop_to_valid got %0d need 2", ov_rise_cyc - pop_cyc); end
        if (done_cyc != xfer_cyc + 1) begin fails++; $display("FAIL xfer_to_done got %0d need 1", done_cyc - xfer_cyc); end
        if (xfer_cyc - ov_rise_cyc != 3) begin fails++; $display("FAIL back_to_back span got %0d need 3", xfer_cyc - ov_rise_cyc); end
        if (done_cnt != d0 + 1) begin fails++; $display("FAIL done_width got %0d need 1", done_cnt - d0); end
    endtask

    task automatic test_multi_pass(input bit toggle, input string nm);
        logic [127:0] exp[2];
        bit ok;
        int d0, bad0;
        exp[0] = rl(row_all(16'd30));
        exp[1] = rl(row_all(-16'sd12));
        @(negedge clk); #1;
        outq.delete();
        for (int p = 0; p < 3; p++) begin
            q.push_back(row_all(16'd10));
            q.push_back(row_all(-16'sd4));
        end
        tog = toggle;
        d0 = done_cnt;
        bad0 = rd_bad;
        start_tile(4'd1, 8'd2);
        wait_done(d0, ok);
        tog = 1'b0;
        repeat (2) @(negedge clk);
        compares += 3;
        if (!ok) begin fails++; $display("FAIL %s_timeout got no done need done", nm); end
        if (rd_bad != bad0) begin fails++; $display("FAIL %s_rd_without_valid got %0d need 0", nm, rd_bad - bad0); end
        if (outq.size() != 2) begin fails++; $display("FAIL %s_count got %0d need 2", nm, outq.size()); end
        for (int i = 0; i < 2; i++) begin
            compares++;
            if (i >= outq.size() || outq[i] !== exp[i]) begin
                fails++;
                $display("FAIL %s_row%0d got %h need %h", nm, i, (i < outq.size()) ? outq[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [127:0] w0, w1, exp[2];
        bit ok;
        int d0;
        w0 = '0; w0[15:0] = 16'h7000; w0[127:112] = 16'd3;
        w1 = '0; w1[15:0] = 16'h9000;
        exp[0] = '0; exp[0][15:0] = 16'h7FFF; exp[0][127:112] = 16'd6;
        exp[1] = '0; exp[1][15:0] = 16'h8000;
        exp[1] = rl(exp[1]);
        @(negedge clk); #1;
        outq.delete();
        q.push_back(w0); q.push_back(w1); q.push_back(w0); q.push_back(w1);
        d0 = done_cnt;
        start_tile(4'd1, 8'd1);
        wait_done(d0, ok);
        repeat (2) @(negedge clk);
        compares++;
        if (!ok) begin fails++; $display("FAIL sat_timeout got no done need done"); end
        for (int i = 0; i < 2; i++) begin
            compares++;
            if (i >= outq.size() || outq[i] !== exp[i]) begin
                fails++;
                $display("FAIL sat_row%0d got %h need %h", i, (i < outq.size()) ? outq[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int d0, k;
        @(negedge clk); #1;
        outq.delete();
        for (int i = 1; i <= 4; i++) q.push_back(row_all(16'(i)));
        out_ready = 1'b0;
        d0 = done_cnt;
        start_tile(4'd3, 8'd0);
        k = 0;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        compares++;
        if (out_valid !== 1'b1 || out_data !== row_all(16'd1)) begin
            fails++; $display("FAIL bp_first got v=%b %h need v=1 %h", out_valid, out_data, row_all(16'd1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compares++;
            if (out_valid !== 1'b1 || out_data !== row_all(16'd2)) begin
                fails++; $display("FAIL bp_hold%0d got v=%b %h need v=1 %h", i, out_valid, out_data, row_all(16'd2));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_done(d0, ok);
        repeat (2) @(negedge clk);
        compares += 2;
        if (!ok) begin fails++; $display("FAIL bp_timeout got no done need done"); end
        if (outq.size() != 4) begin fails++; $display("FAIL bp_count got %0d need 4", outq.size()); end
        for (int i = 0; i < 4; i++) begin
            compares++;
            if (i >= outq.size() || outq[i] !== row_all(16'(i + 1))) begin
                fails++; $display("FAIL bp_row%0d got %h need %h", i, (i < outq.size()) ? outq[i] : '0, row_all(16'(i + 1)));
            end
        end
    endtask

    task automatic test_mid_reset;
        bit ok;
        int d0, k;
        @(negedge clk); #1;
        outq.delete();
        q.push_back(row_all(16'd99));
        q.push_back(row_all(16'd99));
        start_tile(4'd3, 8'd0);
        k = 0;
        while (q.size() != 0 && k < 100) begin @(negedge clk); k++; end
        reset = 1'b0;
        q.push_back(row_all(16'd55));
        @(negedge clk); #1;
        compares += 4;
        if (busy !== 1'b0) begin fails++; $display("FAIL mrst_busy got %b need 0", busy); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_out_valid got %b need 0", out_valid); end
        if (ofifo_rd !== 1'b0) begin fails++; $display("FAIL mrst_ofifo_rd got %b need 0", ofifo_rd); end
        if (q.size() != 1) begin fails++; $display("FAIL mrst_fifo_kept got %0d need 1", q.size()); end
        reset = 1'b1;
        q.delete();
        q.push_back(row_all(16'd3)); q.push_back(row_all(16'd4));
        q.push_back(row_all(16'd1)); q.push_back(row_all(16'd1));
        d0 = done_cnt;
        start_tile(4'd1, 8'd1);
        wait_done(d0, ok);
        repeat (2) @(negedge clk);
        compares += 3;
        if (!ok) begin fails++; $display("FAIL mrst_timeout got no done need done"); end
        if (outq.size() < 1 || outq[0] !== row_all(16'd4)) begin
            fails++; $display("FAIL mrst_row0 got %h need %h", (outq.size() > 0) ? outq[0] : '0, row_all(16'd4));
        end
        if (outq.size() < 2 || outq[1] !== row_all(16'd5)) begin
            fails++; $display("FAIL mrst_row1 got %h need %h", (outq.size() > 1) ? outq[1] : '0, row_all(16'd5));
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        num_pix_m1 = '0;
        num_pass_m1 = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_single_pass;
        test_multi_pass(1'b0, "multi");
        test_saturation;
        test_multi_pass(1'b1, "stall");
        test_backpressure;
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
